// File: rtl/fb_line_reader.sv
// rtl/fb_line_reader.sv - double-buffered frame-buffer line fetcher feeding a pixel pipeline
//
// Fetches each upcoming active line from a word-addressed frame buffer into one
// of two line buffers while the other buffer is being displayed.
//
// Ports:
//   clk, reset                      pixel clock, asynchronous active-high reset
//   in_hsync, in_vsync, in_vde      timing-generator syncs (active-low) and data enable
//   in_x, in_y                      timing-generator pixel / line counters
//   fb_base                         frame-buffer base word address (taken at line 0 fetch)
//   rd_req_valid/addr/ready         read request channel
//   rd_resp_valid/data              in-order read response channel (RGB888)
//   out_hsync, out_vsync, out_vde   timing inputs delayed one cycle
//   out_rgb                         pixel aligned with out_vde, black when line not ready
//   underrun, underrun_clr          sticky late-fetch flag and its synchronous clear
module fb_line_reader #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int V_TOTAL  = 525
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_hsync,
   input  logic        in_vsync,
   input  logic        in_vde,
   input  logic [9:0]  in_x,
   input  logic [9:0]  in_y,
   input  logic [18:0] fb_base,
   output logic        rd_req_valid,
   output logic [18:0] rd_req_addr,
   input  logic        rd_req_ready,
   input  logic        rd_resp_valid,
   input  logic [23:0] rd_resp_data,
   output logic        out_hsync,
   output logic        out_vsync,
   output logic        out_vde,
   output logic [23:0] out_rgb,
   output logic        underrun,
   input  logic        underrun_clr
);

   localparam int CW = $clog2(H_ACTIVE + 1);
   localparam int IW = $clog2(2 * H_ACTIVE);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [18:0] line_addr;
   logic [CW-1:0] req_cnt;
   logic [CW-1:0] resp_cnt;
   logic        tgt_bit;
   logic [1:0]  line_ok;

   logic [9:0]  tgt;
   logic        trig;
   logic        start;
   logic        drop;
   logic        req_fire;
   logic        req_last;
   logic        resp_fire;
   logic        resp_last;
   logic        disp_late;

   logic [23:0] line_mem [2*H_ACTIVE];
   logic [IW-1:0] wr_addr;
   logic [IW-1:0] rd_addr;
   logic        rd_en;
   logic [23:0] rd_data;
   logic        ok_d;

   // ------------------------------------------------------------------
   // Fetch trigger: at the start of every line, look one line ahead.
   // ------------------------------------------------------------------
   always_comb begin
      tgt = (in_y == 10'(V_TOTAL - 1)) ? '0 : in_y + 10'd1;
      trig = (in_x == '0) && (tgt < 10'(V_ACTIVE));
   end

   assign start     = trig && (state == S_IDLE);
   assign drop      = trig && (state != S_IDLE);
   assign req_fire  = rd_req_valid && rd_req_ready;
   assign req_last  = req_fire && (req_cnt == CW'(H_ACTIVE - 1));
   // Responses only belong to a fetch in flight; anything seen while idle is noise.
   assign resp_fire = rd_resp_valid && (state != S_IDLE);
   assign resp_last = resp_fire && (resp_cnt == CW'(H_ACTIVE - 1));

   // ------------------------------------------------------------------
   // Fetch FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   // Fetch FSM: next state
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = S_REQ;
         // Last response may land together with the last acceptance
         // (zero-latency memory); skip DRAIN in that case.
         S_REQ:   if (req_last) state_next = resp_last ? S_IDLE : S_DRAIN;
         S_DRAIN: if (resp_last) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Fetch FSM: outputs
   always_comb begin
      rd_req_valid = (state == S_REQ);
      rd_req_addr  = line_addr + 19'(req_cnt);
   end

   // ------------------------------------------------------------------
   // Fetch datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         line_addr <= '0;
         req_cnt   <= '0;
         resp_cnt  <= '0;
         tgt_bit   <= 1'b0;
      end else if (start) begin
         // Base is only picked up at the top of the frame so a mid-frame
         // fb_base change cannot tear the picture.
         line_addr <= (tgt == '0) ? fb_base : line_addr + 19'(H_ACTIVE);
         req_cnt   <= '0;
         resp_cnt  <= '0;
         tgt_bit   <= tgt[0];
      end else begin
         if (req_fire)
            req_cnt <= req_cnt + CW'(1);
         if (resp_fire)
            resp_cnt <= resp_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         line_ok <= 2'b00;
      end else begin
         if (start)
            line_ok[tgt[0]] <= 1'b0;
         // A dropped fetch leaves stale data from two lines back in its
         // buffer; invalidate it so the line shows black instead. Never touch
         // the buffer the running fetch is filling.
         if (drop && (tgt[0] != tgt_bit))
            line_ok[tgt[0]] <= 1'b0;
         if (resp_last)
            line_ok[tgt_bit] <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Line buffers: both lines share one array, upper half = odd lines.
   // ------------------------------------------------------------------
   assign wr_addr = (tgt_bit ? IW'(H_ACTIVE) : '0) + IW'(resp_cnt);
   assign rd_en   = in_vde && (in_x < 10'(H_ACTIVE));
   assign rd_addr = (in_y[0] ? IW'(H_ACTIVE) : '0) + IW'(in_x);

   always_ff @(posedge clk) begin
      if (resp_fire)
         line_mem[wr_addr] <= rd_resp_data;
   end

   always_ff @(posedge clk) begin
      if (rd_en)
         rd_data <= line_mem[rd_addr];
   end

   // ------------------------------------------------------------------
   // Display pipeline: one register stage for syncs, enable and line status.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_hsync <= 1'b1;
         out_vsync <= 1'b1;
         out_vde   <= 1'b0;
         ok_d      <= 1'b0;
      end else begin
         out_hsync <= in_hsync;
         out_vsync <= in_vsync;
         out_vde   <= in_vde;
         ok_d      <= line_ok[in_y[0]];
      end
   end

   assign out_rgb = (out_vde && ok_d) ? rd_data : 24'h000000;

   // ------------------------------------------------------------------
   // Underrun: fetch still busy at the next trigger, or a line starts
   // displaying before its fetch completed. Set beats clear.
   // ------------------------------------------------------------------
   assign disp_late = in_vde && (in_x == '0) && !line_ok[in_y[0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         underrun <= 1'b0;
      else if (drop || disp_late)
         underrun <= 1'b1;
      else if (underrun_clr)
         underrun <= 1'b0;
   end

endmodule

// File: tb/tb_fb_line_reader.sv
// tb/tb_fb_line_reader.sv - directed self-checking bench for fb_line_reader
module tb_fb_line_reader;

   localparam int H  = 16;
   localparam int V  = 12;
   localparam int VT = 15;
   localparam int HT = 100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_hsync = 1'b1, in_vsync = 1'b1, in_vde = 1'b0;
   logic [9:0]  in_x = '0, in_y = '0;
   logic [18:0] fb_base = '0;
   logic        rd_req_valid;
   logic [18:0] rd_req_addr;
   logic        rd_req_ready = 1'b1;
   logic        rd_resp_valid = 1'b0;
   logic [23:0] rd_resp_data = '0;
   logic        out_hsync, out_vsync, out_vde;
   logic [23:0] out_rgb;
   logic        underrun;
   logic        underrun_clr = 1'b0;

   fb_line_reader #(.H_ACTIVE(H), .V_ACTIVE(V), .V_TOTAL(VT)) dut (
      .clk(clk), .reset(reset),
      .in_hsync(in_hsync), .in_vsync(in_vsync), .in_vde(in_vde),
      .in_x(in_x), .in_y(in_y), .fb_base(fb_base),
      .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
      .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
      .out_hsync(out_hsync), .out_vsync(out_vsync), .out_vde(out_vde),
      .out_rgb(out_rgb), .underrun(underrun), .underrun_clr(underrun_clr)
   );

   always #5 clk = ~clk;

   typedef struct { int due; logic [23:0] data; } ent_t;
   ent_t q[$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int tx = 0, ty = VT - 1;
   int p_x = 0, p_y = 0;
   logic p_hs = 1'b1, p_vs = 1'b1, p_vde = 1'b0, p_clr = 1'b0, p_valid = 1'b0;
   logic chk_en = 1'b0;
   logic exp_urun = 1'b0;
   logic [18:0] exp_base = '0;
   logic [18:0] fetch_base = '0;
   logic [15:0] black = '0;
   int shift_from = 99;
   int urun_line = -1;
   int clr_line = -1;
   int hold_line = -1;
   logic clr_force = 1'b0;
   logic rnd_mode = 1'b0;
   logic alt_ready = 1'b0;
   int acc_total = 0, resp_total = 0;
   int acc_line[16];
   int resp_line[16];
   logic [18:0] first_addr[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic [18:0] pa;
      logic [18:0] off;
      logic [23:0] exp_rgb;
      logic hold_now;
      int ln;
      int dly;
      @(negedge clk);
      cyc++;
      // outputs now reflect the inputs driven one cycle ago
      if (chk_en && p_valid) begin
         if (p_y == urun_line && p_x == 0) exp_urun = 1'b1;
         else if (p_clr) exp_urun = 1'b0;
         if (p_vde && !black[p_y]) begin
            ln = (p_y >= shift_from) ? p_y - 1 : p_y;
            pa = exp_base + 19'(ln * H + p_x);
            exp_rgb = {5'b0, pa};
         end else begin
            exp_rgb = '0;
         end
         chk("hsync", 32'(out_hsync), 32'(p_hs));
         chk("vsync", 32'(out_vsync), 32'(p_vs));
         chk("vde", 32'(out_vde), 32'(p_vde));
         chk("rgb", 32'(out_rgb), 32'(exp_rgb));
         chk("underrun", 32'(underrun), 32'(exp_urun));
         if (p_y == 5 && p_x == 10 && exp_base == 19'h0)
            chk("line5_x10", 32'(out_rgb), 32'd90);
      end
      // memory model: in-order responses, each no earlier than the cycle after acceptance
      hold_now = (hold_line >= 0) && ((ty == hold_line - 1) || (ty == hold_line && tx < 20));
      if (!reset && !hold_now && q.size() > 0 && q[0].due <= cyc) begin
         rd_resp_valid = 1'b1;
         rd_resp_data  = q[0].data;
         off = q[0].data[18:0] - fetch_base;
         ln = int'(off) / H;
         if (ln < 16) resp_line[ln]++;
         resp_total++;
         void'(q.pop_front());
      end else begin
         rd_resp_valid = 1'b0;
      end
      if (rnd_mode)       rd_req_ready = 1'($urandom_range(0, 1));
      else if (alt_ready) rd_req_ready = cyc[0];
      else                rd_req_ready = 1'b1;
      if (rd_req_valid && rd_req_ready) begin
         dly = rnd_mode ? int'($urandom_range(1, 20)) : 1;
         q.push_back('{due: cyc + dly, data: {5'b0, rd_req_addr}});
         off = rd_req_addr - fetch_base;
         ln = int'(off) / H;
         if (ln < 16) acc_line[ln]++;
         if (acc_total % H == 0) first_addr.push_back(rd_req_addr);
         acc_total++;
      end
      // timing generator
      in_x = 10'(tx);
      in_y = 10'(ty);
      in_hsync = !(tx >= 84 && tx < 92);
      in_vsync = !(ty == 13);
      in_vde = (tx < H) && (ty < V);
      underrun_clr = clr_force || (ty == clr_line && tx == 0);
      p_x = tx; p_y = ty;
      p_hs = in_hsync; p_vs = in_vsync; p_vde = in_vde; p_clr = underrun_clr;
      p_valid = 1'b1;
      tx++;
      if (tx == HT) begin
         tx = 0;
         ty = (ty == VT - 1) ? 0 : ty + 1;
      end
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic start_run(input logic [18:0] base);
      acc_total = 0;
      resp_total = 0;
      for (int i = 0; i < 16; i++) begin
         acc_line[i] = 0;
         resp_line[i] = 0;
      end
      first_addr.delete();
      exp_base = base;
      fetch_base = base;
   endtask

   task automatic check_line_counts(input string tag);
      for (int i = 0; i < V; i++) begin
         chk({tag, "_acc"}, 32'(acc_line[i]), 32'(H));
         chk({tag, "_resp"}, 32'(resp_line[i]), 32'(H));
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_req_valid"}, 32'(rd_req_valid), 32'd0);
      chk({tag, "_req_addr"}, 32'(rd_req_addr), 32'd0);
      chk({tag, "_hsync"}, 32'(out_hsync), 32'd1);
      chk({tag, "_vsync"}, 32'(out_vsync), 32'd1);
      chk({tag, "_vde"}, 32'(out_vde), 32'd0);
      chk({tag, "_rgb"}, 32'(out_rgb), 32'd0);
      chk({tag, "_underrun"}, 32'(underrun), 32'd0);
   endtask

   initial begin
      int guard;
      // reset state
      reset = 1'b1;
      run_ticks(3);
      check_reset_values("rst");
      reset = 1'b0;
      tx = 0; ty = VT - 1; p_valid = 1'b0;
      chk_en = 1'b1;

      // frame 1: zero-wait memory, base 0, pixel word = address
      fb_base = 19'h0;
      start_run(19'h0);
      run_ticks(VT * HT);
      check_line_counts("f1");

      // frame 2: base 0x1000; base change at line 3 must not affect this frame
      fb_base = 19'h1000;
      start_run(19'h1000);
      run_ticks(3 * HT);
      fb_base = 19'h2000;
      run_ticks((VT - 3) * HT);
      chk("f2_first_addr_l0", 32'(first_addr[0]), 32'h1000);
      chk("f2_first_addr_l1", 32'(first_addr[1]), 32'h1010);
      chk("f2_acc_total", 32'(acc_total), 32'(V * H));

      // frame 3: random ready and response delay, new base picked up
      rnd_mode = 1'b1;
      start_run(19'h2000);
      run_ticks(VT * HT);
      rnd_mode = 1'b0;
      check_line_counts("f3");

      // frame 4: line 7 responses withheld past its display; base wraps 2^19
      fb_base = 19'h7FF80;
      start_run(19'h7FF80);
      hold_line = 7;
      urun_line = 7;
      clr_line = 7;
      black = 16'h0180;
      shift_from = 9;
      run_ticks(VT * HT);
      hold_line = -1; urun_line = -1; clr_line = -1;
      black = '0; shift_from = 99;
      chk("f4_acc_total", 32'(acc_total), 32'((V - 1) * H));
      chk("f4_resp_total", 32'(resp_total), 32'((V - 1) * H));
      chk("f4_underrun_sticky", 32'(underrun), 32'd1);

      // clear underrun, then reset in the middle of the line 0 fetch
      alt_ready = 1'b1;
      fb_base = 19'h300;
      start_run(19'h300);
      clr_force = 1'b1;
      tick();
      clr_force = 1'b0;
      guard = 0;
      while (acc_total < 10 && guard < 400) begin
         tick();
         guard++;
      end
      chk("f5_req_progress", 32'(acc_total >= 10), 32'd1);
      chk("f5_state_req", 32'(rd_req_valid), 32'd1);
      #2 reset = 1'b1;
      #1;
      check_reset_values("midrst");
      chk_en = 1'b0;
      q.delete();
      alt_ready = 1'b0;
      run_ticks(3);
      reset = 1'b0;
      tx = 0; ty = VT - 1; p_valid = 1'b0;
      chk_en = 1'b1;
      start_run(19'h300);
      run_ticks(VT * HT);
      check_line_counts("f5");
      chk("f5_first_addr", 32'(first_addr[0]), 32'h300);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fb_line_reader.md
FB_LINE_READER -- requirements
Module: fb_line_reader

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, active pixels per line / words fetched per line.
REQ-002 SHALL have parameter V_ACTIVE, 480, active lines per frame.
REQ-003 SHALL have parameter V_TOTAL, 525, total lines per frame incl. blanking.
REQ-004 clk  in  1  pixel clock; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 in_hsync, in_vsync, in_vde  in  1 each  timing-generator sync/enable (syncs active-low).
REQ-007 in_x, in_y  in  10 each  timing-generator pixel/line counters.
REQ-008 fb_base  in  19  frame-buffer word base address, one 24-bit pixel per word.
REQ-009 rd_req_valid  out  1  read request valid.
REQ-010 rd_req_addr  out  19  read word address.
REQ-011 rd_req_ready  in  1  memory accepts request when high with rd_req_valid.
REQ-012 rd_resp_valid  in  1  in-order read data valid.
REQ-013 rd_resp_data  in  24  read data, RGB888.
REQ-014 out_hsync, out_vsync, out_vde  out  1 each  timing inputs delayed one cycle.
REQ-015 out_rgb  out  24  pixel aligned with out_vde.
REQ-016 underrun  out  1  sticky fetch-late flag.
REQ-017 underrun_clr  in  1  synchronous clear of underrun.

Function
REQ-018 SHALL hold two line buffers (H_ACTIVE x 24 each), buffer index = line number bit 0.
REQ-019 Fetch trigger: cycle with in_x==0; target t = (in_y==V_TOTAL-1) ? 0 : in_y+1; trigger valid only if t < V_ACTIVE.
REQ-020 FSM states IDLE, REQ, DRAIN; IDLE->REQ on valid trigger; REQ->DRAIN after H_ACTIVE-th request accepted; DRAIN->IDLE when H_ACTIVE-th response received.
REQ-021 On fetch start: line_addr = (t==0) ? fb_base : line_addr + H_ACTIVE; clear line_ok[t[0]]; request and response counters to 0.
REQ-022 fb_base SHALL be sampled only at t==0 fetch start; changes mid-frame take effect next frame.
REQ-023 In REQ: rd_req_valid=1, rd_req_addr = line_addr + req_cnt (mod 2^19); req_cnt increments only on rd_req_valid && rd_req_ready; addr/valid stable while stalled.
REQ-024 Each rd_resp_valid in REQ or DRAIN writes rd_resp_data to buffer t[0] at index resp_cnt, resp_cnt++; responses may arrive the cycle after acceptance or later, unbounded.
REQ-025 Response counted in the same cycle as H_ACTIVE-th acceptance is valid; FSM SHALL go directly REQ->IDLE if both counts complete together.
REQ-026 line_ok[t[0]] SHALL set in the cycle resp_cnt reaches H_ACTIVE.
REQ-027 rd_resp_valid in IDLE SHALL be ignored.
REQ-028 Valid trigger while not IDLE: trigger dropped, underrun set, current fetch continues unchanged.
REQ-029 Display: buffer in_y[0] read at in_x (synchronous read); out_rgb = data when delayed vde && line_ok[y[0]] at read time, else 24'h000000.
REQ-030 Latency: out_hsync/out_vsync/out_vde/out_rgb SHALL be exactly 1 cycle after corresponding inputs.
REQ-031 Display line v with line_ok clear (fetch incomplete) SHALL also set underrun on first active pixel.
REQ-032 underrun_clr clears underrun; simultaneous set and clear -> set wins.

Reset
REQ-033 On reset: FSM IDLE, counters 0, line_addr 0, line_ok=2'b00, rd_req_valid=0, rd_req_addr=0, out_hsync=1, out_vsync=1, out_vde=0, out_rgb=0, underrun=0; buffer contents undefined.
REQ-034 Reset mid-fetch SHALL abandon the fetch; memory shares reset so no stale responses are expected.

Verification
REQ-035 Zero-wait memory (ready=1, resp next cycle), fb_base=0, pixel word=addr: line 5 active pixel x=10 -> out_rgb=3210 one cycle later, underrun=0 all frame.
REQ-036 Line 0 fetch at y=524,x=0 with fb_base=0x1000 -> first rd_req_addr=0x1000; line 1 fetch first addr=0x1280.
REQ-037 Random ready (50%) and response delay 1-20 cycles -> every displayed pixel correct, no underrun, req/resp counts 640 per line.
REQ-038 Responses withheld beyond 800 cycles on line 7 fetch -> underrun=1, line 7 output all zero, trigger for line 8 dropped, line 8 black; underrun_clr -> 0.
REQ-039 Reset asserted mid-REQ (req_cnt=300) -> rd_req_valid=0 immediately, all outputs at reset values, next frame fetches and displays correctly.
REQ-040 Blanking (y>=480 or x>=640) -> out_vde=0, out_rgb=0, syncs equal inputs delayed 1 cycle.
